// File: rtl/hazard_stall_ctrl_pkg.sv
// Package hazard_pkg: shared types and constants for the hazard/stall sequencer.
//   state_e     : sequencer state encoding (RUN, FLUSH, MEM_WAIT)
//   OP..AUIPC   : RV32 base opcodes needed to decide which source registers an
//                 instruction actually reads
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Interface hazard_stall_ctrl_if: pipeline <-> hazard sequencer signal bundle.
//   master modport (pipeline side): drives IF/ID instruction, ID/EX load info,
//     branch resolution and data-memory busy; receives the control enables.
//   slave modport (sequencer side): the reverse.
//   Controls: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
//     mem_timeout_err, stall_cycles[31:0], flush_cycles[31:0].
interface hazard_stall_ctrl_if;

    logic [31:0] if_id_instr;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        branch_taken;
    logic        dmem_busy;

    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        pipe_freeze;
    logic        mem_timeout_err;
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;

    modport master (
        output if_id_instr, id_ex_mem_read, id_ex_rd, branch_taken, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
               mem_timeout_err, stall_cycles, flush_cycles
    );

    modport slave (
        input  if_id_instr, id_ex_mem_read, id_ex_rd, branch_taken, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
               mem_timeout_err, stall_cycles, flush_cycles
    );

endinterface

// File: rtl/hazard_detect.sv
// Module hazard_detect: combinational load-use hazard compare.
//   instr    in  32  instruction held in IF/ID
//   mem_read in  1   ID/EX instruction is a load
//   rd       in  5   ID/EX destination register
//   hazard   out 1   IF/ID instruction reads the register the load is writing
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        mem_read,
    input  logic [4:0]  rd,
    output logic        hazard
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign unused_bits = ^{instr[31:25], instr[14:7]};

    // Only a field the instruction really reads can create a hazard;
    // U/J-type encodings put immediate bits where rs1/rs2 would be.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            LUI, AUIPC, JAL:   uses_rs1 = 1'b0;
            OP, STORE, BRANCH: uses_rs2 = 1'b1;
            default:           ;
        endcase
    end

    assign hazard = mem_read && (rd != 5'd0) &&
                    ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Module hazard_stall_ctrl: pipeline hazard/stall sequencer for the 5-stage core.
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    slave modport of hazard_stall_ctrl_if (instruction/load/branch/busy in,
//          PC/IF-ID/ID-EX/freeze controls, sticky timeout error, perf counts out)
// Priority in every state: dmem_busy > branch_taken > load-use.
// Build option: define HAZARD_PERF_EN to enable the 32-bit stall/flush cycle
// counters; otherwise stall_cycles and flush_cycles read as zero.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    logic hazard;
    logic run_like;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;

    hazard_detect u_detect (
        .instr    (bus.if_id_instr),
        .mem_read (bus.id_ex_mem_read),
        .rd       (bus.id_ex_rd),
        .hazard   (hazard)
    );

    // MEM_WAIT with memory ready behaves exactly like RUN in the same cycle.
    assign run_like = (state_q != FLUSH) && !((state_q == MEM_WAIT) && bus.dmem_busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        if (run_like) begin
            if (bus.dmem_busy) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = CNT_ONE;
            end else if (bus.branch_taken && (FLUSH_CYCLES > 1)) begin
                state_d     = FLUSH;
                flush_cnt_d = FLUSH_INIT;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == FLUSH) begin
            // A busy memory pauses the flush countdown.
            if (!bus.dmem_busy) begin
                flush_cnt_d = flush_cnt_q - CNT_ONE;
                if (flush_cnt_q == CNT_ONE) begin
                    state_d = RUN;
                end
            end
        end else begin
            // MEM_WAIT, still busy: saturate and flag the timeout.
            if (wait_cnt_q == TIMEOUT) begin
                err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (bus.dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if ((state_q == FLUSH) || bus.branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign bus.pc_write        = pc_write;
    assign bus.if_id_write     = if_id_write;
    assign bus.if_id_flush     = if_id_flush;
    assign bus.id_ex_bubble    = id_ex_bubble;
    assign bus.pipe_freeze     = pipe_freeze;
    assign bus.mem_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flushes_q;

    // Reset already holds both counters at zero, so reset cycles never count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flushes_q   <= '0;
        end else begin
            if (!pc_write) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_id_flush) begin
                flushes_q <= flushes_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_cycles = flushes_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int unsigned FLUSH_N   = 2;
    localparam int unsigned TIMEOUT_N = 3;

    localparam logic [6:0] T_OP = 7'b0110011, T_OPIMM = 7'b0010011, T_LOAD = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011, T_BRANCH = 7'b1100011, T_JAL = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

    typedef struct {
        bit        pcw;
        bit        ifw;
        bit        flush;
        bit        bubble;
        bit        freeze;
        bit        err;
        bit [31:0] stall_n;
        bit [31:0] flush_n;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if bus_if ();

    hazard_stall_ctrl #(
        .FLUSH_CYCLES (FLUSH_N),
        .MEM_TIMEOUT  (TIMEOUT_N),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: flush cycles still owed, length of the current busy
    // streak that started outside a flush, sticky error, perf totals.
    int        m_flush_left = 0;
    int        m_busy_run   = 0;
    bit        m_err        = 0;
    bit [31:0] m_stall      = 0;
    bit [31:0] m_flushes    = 0;

    function automatic bit ref_hazard(logic [31:0] instr, bit mr, logic [4:0] rd);
        logic [6:0] op;
        bit r1, r2;
        op = instr[6:0];
        r1 = !(op == T_LUI || op == T_AUIPC || op == T_JAL);
        r2 = (op == T_OP || op == T_STORE || op == T_BRANCH);
        return mr && rd != 0 && ((r1 && instr[19:15] == rd) || (r2 && instr[24:20] == rd));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(bit rst, logic [31:0] instr, bit mr, logic [4:0] rd, bit br, bit busy);
        exp_t e;
        @(posedge clk);
        #1;
        reset                 = rst;
        bus_if.if_id_instr    = instr;
        bus_if.id_ex_mem_read = mr;
        bus_if.id_ex_rd       = rd;
        bus_if.branch_taken   = br;
        bus_if.dmem_busy      = busy;
        if (rst) begin
            m_flush_left = 0;
            m_busy_run   = 0;
            m_err        = 0;
            m_stall      = 0;
            m_flushes    = 0;
            e = '{pcw: 0, ifw: 0, flush: 1, bubble: 1, freeze: 0, err: 0,
                  stall_n: 0, flush_n: 0};
        end else begin
            e = '{pcw: 1, ifw: 1, flush: 0, bubble: 0, freeze: 0, err: m_err,
                  stall_n: 0, flush_n: 0};
`ifdef HAZARD_PERF_EN
            e.stall_n = m_stall;
            e.flush_n = m_flushes;
`endif
            if (busy) begin
                e.pcw = 0; e.ifw = 0; e.freeze = 1;
                if (m_flush_left == 0) begin
                    m_busy_run++;
                    if (m_busy_run > int'(TIMEOUT_N)) m_err = 1;
                end
            end else begin
                m_busy_run = 0;
                if (m_flush_left > 0) begin
                    e.flush = 1; e.bubble = 1;
                    m_flush_left--;
                end else if (br) begin
                    e.flush = 1; e.bubble = 1;
                    m_flush_left = int'(FLUSH_N) - 1;
                end else if (ref_hazard(instr, mr, rd)) begin
                    e.pcw = 0; e.ifw = 0; e.bubble = 1;
                end
            end
            if (!e.pcw) m_stall++;
            if (e.flush) m_flushes++;
        end
        sb.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle, compare there.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_write", 32'(bus_if.pc_write), 32'(e.pcw));
                check("if_id_write", 32'(bus_if.if_id_write), 32'(e.ifw));
                check("if_id_flush", 32'(bus_if.if_id_flush), 32'(e.flush));
                check("id_ex_bubble", 32'(bus_if.id_ex_bubble), 32'(e.bubble));
                check("pipe_freeze", 32'(bus_if.pipe_freeze), 32'(e.freeze));
                check("mem_timeout_err", 32'(bus_if.mem_timeout_err), 32'(e.err));
                check("stall_cycles", bus_if.stall_cycles, e.stall_n);
                check("flush_cycles", bus_if.flush_cycles, e.flush_n);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] add_x6_x5_x7, lui_x5, addi_x6, r, instr;
        logic [6:0]  ops [10];
        logic [4:0]  rd, rs1, rs2;
        int          busy_left;
        bit          br, mr, rst;

        add_x6_x5_x7 = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, T_OP};
        lui_x5       = {20'h1, 5'd5, T_LUI};
        addi_x6      = {12'd1, 5'd0, 3'd0, 5'd6, T_OPIMM};
        ops = '{T_OP, T_OPIMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC,
                7'b1110011};

        bus_if.if_id_instr    = '0;
        bus_if.id_ex_mem_read = 1'b0;
        bus_if.id_ex_rd       = '0;
        bus_if.branch_taken   = 1'b0;
        bus_if.dmem_busy      = 1'b0;

        // Reset, then release into RUN.
        repeat (3) drive(1, addi_x6, 0, 0, 0, 0);
        drive(0, addi_x6, 0, 0, 0, 0);
        // Load-use, then rd=x0, then unused/non-matching sources.
        drive(0, add_x6_x5_x7, 1, 5, 0, 0);
        drive(0, add_x6_x5_x7, 1, 0, 0, 0);
        drive(0, lui_x5, 1, 5, 0, 0);
        drive(0, addi_x6, 1, 5, 0, 0);
        // Branch flush; load-use in the second flush cycle is ignored.
        drive(0, addi_x6, 0, 0, 1, 0);
        drive(0, add_x6_x5_x7, 1, 5, 0, 0);
        drive(0, addi_x6, 0, 0, 0, 0);
        // Memory busy during FLUSH pauses the flush.
        drive(0, addi_x6, 0, 0, 1, 0);
        repeat (4) drive(0, addi_x6, 0, 0, 0, 1);
        repeat (2) drive(0, addi_x6, 0, 0, 0, 0);
        // Busy five cycles from RUN -> sticky timeout error.
        repeat (5) drive(0, addi_x6, 0, 0, 0, 1);
        repeat (3) drive(0, add_x6_x5_x7, 1, 5, 0, 0);
        // Busy and branch together: freeze only, branch dropped.
        drive(0, addi_x6, 0, 0, 1, 1);
        drive(0, addi_x6, 0, 0, 0, 0);
        // Busy released with a branch in the same cycle: branch honoured.
        drive(0, addi_x6, 0, 0, 0, 1);
        drive(0, addi_x6, 0, 0, 1, 0);
        // Reset in the middle of a flush drops it.
        drive(1, addi_x6, 0, 0, 0, 0);
        drive(0, addi_x6, 0, 0, 0, 0);
        drive(0, addi_x6, 0, 0, 1, 0);
        drive(1, addi_x6, 0, 0, 0, 0);
        repeat (2) drive(0, addi_x6, 0, 0, 0, 0);

        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom();
            rd  = r[4:0];
            rs1 = (r[5] || r[6]) ? rd : r[11:7];
            rs2 = r[12] ? rd : r[17:13];
            r   = $urandom();
            instr = {r[31:25], rs2, rs1, r[14:12], r[11:7], ops[$urandom_range(0, 9)]};
            mr  = ($urandom_range(0, 2) != 0);
            br  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 7);
            drive(rst, instr, mr, rd, br, busy_left > 0);
            if (busy_left > 0) busy_left--;
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
